// File: rtl/data_packer.sv
// data_packer: gathers IN_WIDTH-bit input beats into OUT_WIDTH-bit words.
// The first beat of a word goes in the least significant lane. A word is
// emitted when it is full or when a frame-final beat arrives. Unfilled lanes
// are zero, so a zero-padded partial word keeps its population count.
module data_packer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 128
) (
    input  logic                                        clk_i,
    input  logic                                        arst_i,
    input  logic [IN_WIDTH-1:0]                         data_i,
    input  logic                                        data_val_i,
    input  logic                                        data_last_i,
    output logic [OUT_WIDTH-1:0]                        data_o,
    output logic                                        data_val_o,
    output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]         data_beats_o,
    output logic                                        data_last_o
);

    localparam int N       = OUT_WIDTH / IN_WIDTH;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int BEATS_W = $clog2(N) + 1;

    // Reject geometries that cannot be split into at least two whole lanes.
    generate
        if ((OUT_WIDTH % IN_WIDTH) != 0 || N < 2) begin : g_bad_geometry
            $error("data_packer: OUT_WIDTH must be a multiple of IN_WIDTH with at least 2 lanes");
        end
    endgenerate

    // Next lane to fill, the partial word, and the registered output word.
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [OUT_WIDTH-1:0] buf_q,   buf_d;
    logic [OUT_WIDTH-1:0] word_q,  word_d;
    logic                 val_q,   val_d;
    logic [BEATS_W-1:0]   beats_q, beats_d;
    logic                 last_q,  last_d;

    // Pack buffer with the current beat merged into lane cnt_q. Lanes above
    // cnt_q are still zero because the buffer is cleared whenever a word closes.
    logic [OUT_WIDTH-1:0] fill_word;
    logic                 close_word;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign fill_word[gi*IN_WIDTH +: IN_WIDTH] =
                (data_val_i && (cnt_q == CNT_W'(gi))) ? data_i
                                                      : buf_q[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    assign close_word = data_val_i && ((cnt_q == CNT_W'(N - 1)) || data_last_i);

    // Next-state: advance the lane on each valid beat; on close, publish the
    // word and restart from lane 0 with an empty buffer in the same cycle.
    always_comb begin
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        word_d  = word_q;
        val_d   = 1'b0;
        beats_d = beats_q;
        last_d  = last_q;
        if (data_val_i) begin
            if (close_word) begin
                cnt_d   = '0;
                buf_d   = '0;
                word_d  = fill_word;
                val_d   = 1'b1;
                beats_d = BEATS_W'(cnt_q) + BEATS_W'(1);
                last_d  = data_last_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                buf_d = fill_word;
            end
        end
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q   <= '0;
            buf_q   <= '0;
            word_q  <= '0;
            val_q   <= 1'b0;
            beats_q <= '0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            word_q  <= word_d;
            val_q   <= val_d;
            beats_q <= beats_d;
            last_q  <= last_d;
        end
    end

    assign data_o       = word_q;
    assign data_val_o   = val_q;
    assign data_beats_o = beats_q;
    assign data_last_o  = last_q;

endmodule

// File: tb/tb_data_packer.sv
// Directed testbench for data_packer (IN_WIDTH=16, OUT_WIDTH=128, N=8).
module tb_data_packer;

    logic         clk_i;
    logic         arst_i;
    logic [15:0]  data_i;
    logic         data_val_i;
    logic         data_last_i;
    logic [127:0] data_o;
    logic         data_val_o;
    logic [3:0]   data_beats_o;
    logic         data_last_o;

    data_packer #(
        .IN_WIDTH  (16),
        .OUT_WIDTH (128)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .data_i       (data_i),
        .data_val_i   (data_val_i),
        .data_last_i  (data_last_i),
        .data_o       (data_o),
        .data_val_o   (data_val_o),
        .data_beats_o (data_beats_o),
        .data_last_o  (data_last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         val;
        logic         last;
        logic [15:0]  data;
        logic         ev;
        logic [127:0] ed;
        logic [3:0]   eb;
        logic         el;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Output values expected to be held between pulses.
    logic [127:0] hold_d = '0;
    logic [3:0]   hold_b = '0;
    logic         hold_l = 1'b0;

    function automatic void add_beat(logic val, logic last, logic [15:0] data);
        vec_t v;
        v.val = val; v.last = last; v.data = data;
        v.ev = 1'b0; v.ed = hold_d; v.eb = hold_b; v.el = hold_l;
        vecs.push_back(v);
    endfunction

    function automatic void add_close(logic last, logic [15:0] data,
                                      logic [127:0] ed, logic [3:0] eb);
        vec_t v;
        v.val = 1'b1; v.last = last; v.data = data;
        v.ev = 1'b1; v.ed = ed; v.eb = eb; v.el = last;
        hold_d = ed; hold_b = eb; hold_l = last;
        vecs.push_back(v);
    endfunction

    task automatic check_out(string tag, int idx, logic ev, logic [127:0] ed,
                             logic [3:0] eb, logic el);
        checks++;
        if (data_val_o !== ev) begin
            errors++;
            $display("FAIL %s[%0d] data_val_o got %b want %b", tag, idx, data_val_o, ev);
        end
        checks++;
        if (data_o !== ed) begin
            errors++;
            $display("FAIL %s[%0d] data_o got %h want %h", tag, idx, data_o, ed);
        end
        checks++;
        if (data_beats_o !== eb) begin
            errors++;
            $display("FAIL %s[%0d] data_beats_o got %0d want %0d", tag, idx, data_beats_o, eb);
        end
        checks++;
        if (data_last_o !== el) begin
            errors++;
            $display("FAIL %s[%0d] data_last_o got %b want %b", tag, idx, data_last_o, el);
        end
    endtask

    task automatic apply(vec_t v, string tag, int idx);
        @(negedge clk_i);
        data_val_i  = v.val;
        data_last_i = v.last;
        data_i      = v.data;
        @(posedge clk_i);
        #1;
        check_out(tag, idx, v.ev, v.ed, v.eb, v.el);
        $display("%s[%0d] val=%b last=%b data=%h -> val_o=%b beats=%0d last_o=%b data_o=%h",
                 tag, idx, v.val, v.last, v.data, data_val_o, data_beats_o, data_last_o, data_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        arst_i      = 1'b1;
        data_i      = '0;
        data_val_i  = 1'b0;
        data_last_i = 1'b0;

        // Reset state before any clock edge.
        #2;
        check_out("reset", 0, 1'b0, 128'h0, 4'd0, 1'b0);
        @(negedge clk_i);
        arst_i = 1'b0;

        // 8 beats 1..8, no last -> full word.
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) add_beat(1'b1, 1'b0, 16'(k));
            else add_close(1'b0, 16'(k), 128'h0008_0007_0006_0005_0004_0003_0002_0001, 4'd8);
        end
        add_beat(1'b0, 1'b0, 16'h0);
        // 3 beats 0xFFFF, last on beat 3; next beat lands in lane 0.
        add_beat(1'b1, 1'b0, 16'hFFFF);
        add_beat(1'b1, 1'b0, 16'hFFFF);
        add_close(1'b1, 16'hFFFF, 128'h0000_0000_0000_0000_0000_FFFF_FFFF_FFFF, 4'd3);
        add_close(1'b1, 16'h1234, 128'h0000_0000_0000_0000_0000_0000_0000_1234, 4'd1);
        // 8 beats with idle gaps and stray last pulses while invalid.
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) add_beat(1'b1, 1'b0, 16'(k));
            else add_close(1'b0, 16'(k), 128'h0008_0007_0006_0005_0004_0003_0002_0001, 4'd8);
            for (int g = 0; g < (k % 3); g++) add_beat(1'b0, 1'b1, 16'hDEAD);
        end
        // Last on beat 8 -> single pulse, beats 8, last 1.
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) add_beat(1'b1, 1'b0, 16'h1000 + 16'(k));
            else add_close(1'b1, 16'h1008, 128'h1008_1007_1006_1005_1004_1003_1002_1001, 4'd8);
        end
        // 16 back-to-back beats -> two pulses 8 cycles apart.
        for (int k = 0; k < 16; k++) begin
            if (k == 7) add_close(1'b0, 16'h0107, 128'h0107_0106_0105_0104_0103_0102_0101_0100, 4'd8);
            else if (k == 15) add_close(1'b0, 16'h010F, 128'h010F_010E_010D_010C_010B_010A_0109_0108, 4'd8);
            else add_beat(1'b1, 1'b0, 16'h0100 + 16'(k));
        end
        // 5 beats of a word that reset will discard.
        for (int k = 0; k < 5; k++) add_beat(1'b1, 1'b0, 16'h0EE0 + 16'(k));

        foreach (vecs[i]) apply(vecs[i], "vec", i);

        // Asynchronous reset in mid-cycle: outputs clear before the next edge.
        #2;
        data_val_i = 1'b0;
        arst_i     = 1'b1;
        #1;
        check_out("arst_async", 0, 1'b0, 128'h0, 4'd0, 1'b0);
        @(posedge clk_i);
        #1;
        check_out("arst_edge", 0, 1'b0, 128'h0, 4'd0, 1'b0);
        #2;
        arst_i = 1'b0;
        hold_d = '0; hold_b = '0; hold_l = 1'b0;

        // Beats 0xA0..0xA7 starting on the first edge after reset release.
        vecs.delete();
        for (int k = 0; k < 8; k++) begin
            if (k < 7) add_beat(1'b1, 1'b0, 16'h00A0 + 16'(k));
            else add_close(1'b0, 16'h00A7, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0, 4'd8);
        end
        add_beat(1'b0, 1'b0, 16'h0);
        foreach (vecs[i]) apply(vecs[i], "post_rst", i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
